// File: rtl/bcd_mod_counter_disp_if.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter_disp_if
// Bundles the control and display signals of the BCD modulo counter.
//   master : drives en, up_dn, load, load_val; observes the count, pulses, HEX
//   slave  : the counter itself (consumes controls, produces outputs)
// Signals:
//   en        count enable (gates prescaler and stepping)
//   up_dn     1 = count up, 0 = count down
//   load      parallel load strobe
//   load_val  BCD load value, digit 0 in [3:0]
//   bcd_out   registered BCD count, digit 0 in [3:0]
//   carry_out one-cycle pulse on wrap
//   tick_out  one-cycle pulse on every count step
//   load_err  one-cycle pulse when a load is rejected
//   HEX       active-low 7-segment patterns {g..a}, digit 0 in [6:0]
// ---------------------------------------------------------------------------
interface bcd_mod_counter_disp_if #(
    parameter int DIGITS = 2
) ();
    logic                  en;
    logic                  up_dn;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  carry_out;
    logic                  tick_out;
    logic                  load_err;
    logic [7*DIGITS-1:0]   HEX;

    modport master (
        output en, up_dn, load, load_val,
        input  bcd_out, carry_out, tick_out, load_err, HEX
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output bcd_out, carry_out, tick_out, load_err, HEX
    );
endinterface

// File: rtl/bcd_mod_counter_disp.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter_disp
// N-digit BCD modulo counter with prescaler, parallel load, up/down mode,
// wrap carry and per-digit active-low 7-segment decode.
// Ports:
//   CLOCK_50  single rising-edge clock
//   reset     synchronous, active-high
//   bus       slave side of bcd_mod_counter_disp_if (controls, count, pulses,
//             HEX)
// Parameters:
//   DIGITS    number of BCD digits (1..8)
//   MODULUS   count range 0..MODULUS-1
//   PRESCALE  enabled clock cycles per count step
//   BLANK_LZ  1 = blank leading zero digits (digit 0 always lit)
// ---------------------------------------------------------------------------
module bcd_mod_counter_disp #(
    parameter int DIGITS   = 2,
    parameter int MODULUS  = 60,
    parameter int PRESCALE = 50000000,
    parameter int BLANK_LZ = 0
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    bcd_mod_counter_disp_if.slave  bus
);

    localparam int W   = 4 * DIGITS;
    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Integer to packed BCD; used only for elaboration-time constants.
    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] r;
        int           v;
        r = {W{1'b0}};
        v = value;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    // Active-low {g..a} pattern for one BCD digit; non-decimal codes dark.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    localparam logic [W-1:0]   MAX_BCD  = to_bcd(MODULUS - 1);
    localparam logic [W-1:0]   ZERO_BCD = {W{1'b0}};
    localparam logic [PCW-1:0] PC_MAX   = PCW'(PRESCALE - 1);
    localparam bit             BLANK_EN = (BLANK_LZ != 0);

    logic [W-1:0]     count_q, count_d;
    logic [PCW-1:0]   pc_q, pc_d;
    logic             carry_q, carry_d;
    logic             tick_q, tick_d;
    logic             load_err_q, load_err_d;

    logic [W-1:0]     inc_s, dec_s, step_val_s;
    logic             inc_c_s, dec_b_s;
    logic             step_s, wrap_s, load_ok_s, digits_ok_s;
    logic             zero_above_s;
    logic [7*DIGITS-1:0] hex_s;

    // Per-digit BCD increment and decrement with ripple carry/borrow.
    always_comb begin
        inc_s   = count_q;
        dec_s   = count_q;
        inc_c_s = 1'b1;
        dec_b_s = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (inc_c_s) begin
                if (count_q[4*k +: 4] == 4'd9) begin
                    inc_s[4*k +: 4] = 4'd0;
                end else begin
                    inc_s[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                    inc_c_s         = 1'b0;
                end
            end else begin
                inc_s[4*k +: 4] = count_q[4*k +: 4];
            end
            if (dec_b_s) begin
                if (count_q[4*k +: 4] == 4'd0) begin
                    dec_s[4*k +: 4] = 4'd9;
                end else begin
                    dec_s[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
                    dec_b_s         = 1'b0;
                end
            end else begin
                dec_s[4*k +: 4] = count_q[4*k +: 4];
            end
        end
    end

    // Load validation: every digit decimal and value below the modulus.
    // With all digits decimal, packed-BCD ordering equals numeric ordering.
    always_comb begin
        digits_ok_s = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (bus.load_val[4*k +: 4] > 4'd9) begin
                digits_ok_s = 1'b0;
            end else begin
                digits_ok_s = digits_ok_s;
            end
        end
        load_ok_s = digits_ok_s && (bus.load_val <= MAX_BCD);
    end

    // Step value selection including modulo wrap in both directions.
    always_comb begin
        step_s = bus.en && (pc_q == PC_MAX);
        if (bus.up_dn) begin
            wrap_s     = (count_q == MAX_BCD);
            step_val_s = wrap_s ? ZERO_BCD : inc_s;
        end else begin
            wrap_s     = (count_q == ZERO_BCD);
            step_val_s = wrap_s ? MAX_BCD : dec_s;
        end
    end

    // Next-state: load beats step; a rejected load freezes count and prescaler.
    always_comb begin
        count_d    = count_q;
        pc_d       = pc_q;
        carry_d    = 1'b0;
        tick_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (load_ok_s) begin
                count_d = bus.load_val;
                pc_d    = {PCW{1'b0}};
            end else begin
                load_err_d = 1'b1;
            end
        end else if (step_s) begin
            count_d = step_val_s;
            pc_d    = {PCW{1'b0}};
            tick_d  = 1'b1;
            carry_d = wrap_s;
        end else if (bus.en) begin
            pc_d = pc_q + PCW'(1'b1);
        end else begin
            pc_d = pc_q;
        end
    end

    // State and pulse registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count_q    <= {W{1'b0}};
            pc_q       <= {PCW{1'b0}};
            carry_q    <= 1'b0;
            tick_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            pc_q       <= pc_d;
            carry_q    <= carry_d;
            tick_q     <= tick_d;
            load_err_q <= load_err_d;
        end
    end

    // Segment decode, scanning from the top digit to track leading zeros.
    always_comb begin
        hex_s        = {(7*DIGITS){1'b1}};
        zero_above_s = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above_s = zero_above_s && (count_q[4*k +: 4] == 4'd0);
            if (BLANK_EN && (k > 0) && zero_above_s) begin
                hex_s[7*k +: 7] = 7'h7F;
            end else begin
                hex_s[7*k +: 7] = seg7(count_q[4*k +: 4]);
            end
        end
    end

    assign bus.bcd_out   = count_q;
    assign bus.carry_out = carry_q;
    assign bus.tick_out  = tick_q;
    assign bus.load_err  = load_err_q;
    assign bus.HEX       = hex_s;

endmodule

// File: tb/tb_bcd_mod_counter_disp.sv
// ---------------------------------------------------------------------------
// tb_bcd_mod_counter_disp
// Two instances: A (2 digits, mod 60, prescale 4) and B (4 digits, mod 10000,
// prescale 1, leading-zero blanking). Stimulus pushes expected pulse events
// (cycle, count, carry, tick, load_err) into per-instance queues; monitors pop
// and compare whenever an instance raises any pulse. Non-pulse results (load
// values, reset state, HEX patterns) are compared directly.
// ---------------------------------------------------------------------------
module tb_bcd_mod_counter_disp;

    typedef struct {
        int          cyc;
        logic [31:0] bcd;
        logic        carry;
        logic        tick;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   cyc;
    int   checks;
    int   errors;
    exp_t qa[$];
    exp_t qb[$];

    bcd_mod_counter_disp_if #(.DIGITS(2)) ifa ();
    bcd_mod_counter_disp_if #(.DIGITS(4)) ifb ();

    bcd_mod_counter_disp #(.DIGITS(2), .MODULUS(60), .PRESCALE(4), .BLANK_LZ(0)) dut_a (
        .CLOCK_50 (clk),
        .reset    (rst_a),
        .bus      (ifa)
    );

    bcd_mod_counter_disp #(.DIGITS(4), .MODULUS(10000), .PRESCALE(1), .BLANK_LZ(1)) dut_b (
        .CLOCK_50 (clk),
        .reset    (rst_b),
        .bus      (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bcd2(input int v);
        return 32'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic exp_t mk(input int c, input logic [31:0] b, input logic cy,
                                input logic tk, input logic er);
        exp_t e;
        e.cyc = c; e.bcd = b; e.carry = cy; e.tick = tk; e.err = er;
        return e;
    endfunction

    // Scoreboard monitor for instance A.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifa.tick_out || ifa.carry_out || ifa.load_err) begin
                checks = checks + 1;
                if (qa.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL sb_a unexpected cyc %0d bcd %h c%b t%b e%b", cyc,
                             ifa.bcd_out, ifa.carry_out, ifa.tick_out, ifa.load_err);
                end else begin
                    e = qa.pop_front();
                    if (e.cyc != cyc || e.bcd != 32'(ifa.bcd_out) || e.carry != ifa.carry_out ||
                        e.tick != ifa.tick_out || e.err != ifa.load_err) begin
                        errors = errors + 1;
                        $display("FAIL sb_a got cyc %0d bcd %h c%b t%b e%b want cyc %0d bcd %h c%b t%b e%b",
                                 cyc, ifa.bcd_out, ifa.carry_out, ifa.tick_out, ifa.load_err,
                                 e.cyc, e.bcd, e.carry, e.tick, e.err);
                    end
                end
            end
        end
    end

    // Scoreboard monitor for instance B.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifb.tick_out || ifb.carry_out || ifb.load_err) begin
                checks = checks + 1;
                if (qb.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL sb_b unexpected cyc %0d bcd %h c%b t%b e%b", cyc,
                             ifb.bcd_out, ifb.carry_out, ifb.tick_out, ifb.load_err);
                end else begin
                    e = qb.pop_front();
                    if (e.cyc != cyc || e.bcd != 32'(ifb.bcd_out) || e.carry != ifb.carry_out ||
                        e.tick != ifb.tick_out || e.err != ifb.load_err) begin
                        errors = errors + 1;
                        $display("FAIL sb_b got cyc %0d bcd %h c%b t%b e%b want cyc %0d bcd %h c%b t%b e%b",
                                 cyc, ifb.bcd_out, ifb.carry_out, ifb.tick_out, ifb.load_err,
                                 e.cyc, e.bcd, e.carry, e.tick, e.err);
                    end
                end
            end
        end
    end

    initial begin
        int c;
        checks = 0;
        errors = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.en = 1'b0; ifa.up_dn = 1'b1; ifa.load = 1'b0; ifa.load_val = 8'h00;
        ifb.en = 1'b0; ifb.up_dn = 1'b1; ifb.load = 1'b0; ifb.load_val = 16'h0000;
        tick(3);

        // Reset state
        chk("a_rst_bcd", 64'(ifa.bcd_out), 64'h0);
        chk("a_rst_pulses", 64'({ifa.carry_out, ifa.tick_out, ifa.load_err}), 64'h0);
        chk("a_rst_hex", 64'(ifa.HEX), 64'({7'b1000000, 7'b1000000}));
        chk("b_rst_hex", 64'(ifb.HEX), 64'({7'h7F, 7'h7F, 7'h7F, 7'b1000000}));

        // Up count through a full wrap: one step every 4 enabled cycles
        c = cyc;
        rst_a = 1'b0; ifa.en = 1'b1; ifa.up_dn = 1'b1;
        for (int k = 1; k <= 60; k++) qa.push_back(mk(c + 4*k, bcd2(k % 60), (k == 60), 1'b1, 1'b0));
        tick(240);

        // Down from reset: 00 -> 59 with carry, then down to 09 across the 10 borrow
        rst_a = 1'b1;
        tick(2);
        c = cyc;
        rst_a = 1'b0; ifa.up_dn = 1'b0;
        for (int k = 1; k <= 51; k++) qa.push_back(mk(c + 4*k, bcd2(60 - k), (k == 1), 1'b1, 1'b0));
        tick(204);

        // Valid load then two rejected loads (bad digit, value >= modulus)
        c = cyc;
        ifa.en = 1'b0; ifa.up_dn = 1'b1; ifa.load = 1'b1; ifa.load_val = 8'h37;
        tick(1);
        chk("a_load_37", 64'(ifa.bcd_out), 64'h37);
        chk("a_hex_37", 64'(ifa.HEX), 64'({7'b0110000, 7'b1111000}));
        ifa.load_val = 8'h1A;
        qa.push_back(mk(c + 2, 32'h37, 1'b0, 1'b0, 1'b1));
        tick(1);
        ifa.load_val = 8'h60;
        qa.push_back(mk(c + 3, 32'h37, 1'b0, 1'b0, 1'b1));
        tick(1);
        ifa.load = 1'b0;
        tick(2);
        chk("a_reject_hold", 64'(ifa.bcd_out), 64'h37);

        // Load on the step edge wins (no tick); following step wraps 59 -> 00
        c = cyc;
        ifa.en = 1'b1;
        qa.push_back(mk(c + 8, 32'h00, 1'b1, 1'b1, 1'b0));
        tick(3);
        ifa.load = 1'b1; ifa.load_val = 8'h59;
        tick(1);
        ifa.load = 1'b0;
        chk("a_load_on_step", 64'(ifa.bcd_out), 64'h59);
        tick(4);

        // Reset coinciding with step and load wins
        c = cyc;
        ifa.load = 1'b1; ifa.load_val = 8'h41;
        tick(1);
        ifa.load = 1'b0;
        chk("a_load_41", 64'(ifa.bcd_out), 64'h41);
        tick(3);
        rst_a = 1'b1; ifa.load = 1'b1; ifa.load_val = 8'h25;
        tick(1);
        chk("a_rst_over_load", 64'(ifa.bcd_out), 64'h0);
        chk("a_rst_over_pulses", 64'({ifa.carry_out, ifa.tick_out, ifa.load_err}), 64'h0);
        rst_a = 1'b0; ifa.load = 1'b0;
        qa.push_back(mk(c + 9, 32'h01, 1'b0, 1'b1, 1'b0));
        tick(4);

        // en dropped 7 cycles mid-interval delays the step by exactly 7
        c = cyc;
        qa.push_back(mk(c + 11, 32'h02, 1'b0, 1'b1, 1'b0));
        tick(2);
        ifa.en = 1'b0;
        tick(7);
        ifa.en = 1'b1;
        tick(2);

        // en dropped while prescaler sits at its last value: step waits for en
        c = cyc;
        qa.push_back(mk(c + 9, 32'h03, 1'b0, 1'b1, 1'b0));
        tick(3);
        ifa.en = 1'b0;
        tick(5);
        ifa.en = 1'b1;
        tick(1);
        ifa.en = 1'b0;
        tick(2);
        chk("a_final", 64'(ifa.bcd_out), 64'h03);

        // Instance B: blanking, interior zeros, rejected load, 9999 -> 0000 wrap
        rst_b = 1'b0;
        ifb.load = 1'b1; ifb.load_val = 16'h0042;
        tick(1);
        chk("b_load_42", 64'(ifb.bcd_out), 64'h0042);
        chk("b_hex_hi_blank", 64'(ifb.HEX[27:14]), 64'({7'h7F, 7'h7F}));
        chk("b_hex_lo_42", 64'(ifb.HEX[13:0]), 64'({7'b0011001, 7'b0100100}));
        ifb.load_val = 16'h0100;
        tick(1);
        chk("b_hex_0100", 64'(ifb.HEX), 64'({7'h7F, 7'b1111001, 7'b1000000, 7'b1000000}));
        c = cyc;
        qb.push_back(mk(c + 1, 32'h0100, 1'b0, 1'b0, 1'b1));
        ifb.load_val = 16'h9A00;
        tick(1);
        ifb.load_val = 16'h9998;
        tick(1);
        ifb.load = 1'b0;
        chk("b_load_9998", 64'(ifb.bcd_out), 64'h9998);
        c = cyc;
        ifb.en = 1'b1;
        qb.push_back(mk(c + 1, 32'h9999, 1'b0, 1'b1, 1'b0));
        qb.push_back(mk(c + 2, 32'h0000, 1'b1, 1'b1, 1'b0));
        tick(2);
        ifb.en = 1'b0;
        tick(2);
        chk("b_wrap_bcd", 64'(ifb.bcd_out), 64'h0000);
        chk("b_hex_zero", 64'(ifb.HEX), 64'({7'h7F, 7'h7F, 7'h7F, 7'b1000000}));

        // Drain the scoreboards with a bounded wait
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) tick(1);
        chk("sb_a_drained", 64'(qa.size()), 64'h0);
        chk("sb_b_drained", 64'(qb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter_disp.md
# bcd_mod_counter_disp

Parametrised N-digit BCD modulo counter with built-in prescaler, parallel load, up/down mode, wrap carry and per-digit 7-segment drivers. Successor to the fixed 2-digit counter/display path: replaces the binary-counter-plus-convert/mux structure with native BCD digits and any modulus up to 10^DIGITS. Sits between CLOCK_50 and the board HEX displays; carry_out cascades into the next stage's en (seconds -> minutes -> hours).

## Interface
- DIGITS, 2: number of BCD digits (1..8).
- MODULUS, 60: count range 0..MODULUS-1; 2 <= MODULUS <= 10^DIGITS.
- PRESCALE, 50000000: enabled clock cycles per count step (>= 1).
- BLANK_LZ, 0: 1 = blank leading zero digits on HEX (digit 0 never blanked).

- CLOCK_50  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- en  in  1  count enable; gates prescaler and stepping.
- up_dn  in  1  1 = count up, 0 = count down; sampled at each step.
- load  in  1  parallel load strobe.
- load_val  in  4*DIGITS  BCD load value, digit 0 in [3:0].
- bcd_out  out  4*DIGITS  registered count, BCD, digit 0 in [3:0].
- carry_out  out  1  one-cycle pulse on wrap.
- tick_out  out  1  one-cycle pulse on every count step.
- load_err  out  1  one-cycle pulse when a load is rejected.
- HEX  out  7*DIGITS  active-low segments {g..a} per digit, digit 0 in [6:0].

## Operation
- Prescaler pc, width clog2(PRESCALE), range 0..PRESCALE-1; increments only while en=1; holds while en=0.
- Step condition: en=1 and pc==PRESCALE-1; on that edge pc returns to 0 and the count steps.
- Up step: count+1; at MODULUS-1 wraps to 0 with carry_out.
- Down step: count-1; at 0 wraps to MODULUS-1 with carry_out.
- Arithmetic is per-digit BCD with ripple carry/borrow; no digit ever leaves 0..9; no binary intermediate wider than 4 bits per digit.
- Load: valid when every digit of load_val <= 9 and value < MODULUS. Valid load -> bcd_out=load_val, pc=0. Invalid load -> count and pc unchanged, load_err pulses.
- Priority per edge: reset > load > step. Load is independent of en. A load coinciding with a step suppresses the step; no tick_out, no carry_out.
- HEX: each digit decoded 0..9 to standard active-low patterns (0 = 7'b1000000). Values 10..15 unreachable; decode to all-off 7'h7F.
- BLANK_LZ=1: digit k>0 drives 7'h7F if it and all higher digits are 0.

## Timing
- Reset values: bcd_out=0, pc=0, carry_out=0, tick_out=0, load_err=0; HEX shows 0 in digit 0, digits >0 show 0 (BLANK_LZ=0) or blank (BLANK_LZ=1).
- Reset mid-count overrides load and step on the same edge; counting resumes PRESCALE enabled cycles after reset deasserts.
- tick_out, carry_out, load_err are registered; they are high during the cycle in which bcd_out first shows the new value (carry_out with 0 after up wrap, MODULUS-1 after down wrap).
- Load latency 1 cycle: bcd_out = load_val on the cycle after load is sampled.
- HEX is combinational from bcd_out: zero added latency.
- en deasserted on the step cycle: no step; pc holds at PRESCALE-1, step fires on the first cycle en returns.
- PRESCALE=1: step on every enabled cycle; tick_out continuously high while en=1.
- up_dn change takes effect on the next step only.

## Test plan
- DIGITS=2, MODULUS=60, PRESCALE=4, up: release reset, en=1 -> bcd_out 0x00,0x01,... each 4 cycles; 0x59 -> 0x00 with carry_out one cycle; tick_out 1-in-4.
- Down from reset: up_dn=0 -> first step gives 0x59 with carry_out; next 0x58; 0x10 -> 0x09 (borrow across digits).
- Load: load_val=0x37 -> bcd_out 0x37 next cycle, pc=0, no tick; load_val=0x1A and 0x60 -> load_err pulse, count unchanged.
- Load on step cycle and reset on step+load cycle: load wins with no carry/tick; reset wins giving 0x00 and all pulses low.
- en toggling: drop en for 7 cycles mid-interval -> step delayed exactly 7 cycles; dropping en on pc==3 delays step until en=1.
- DIGITS=4, MODULUS=10000, PRESCALE=1, BLANK_LZ=1: 9999 -> 0000 carry; count 0x0042 -> HEX[27:14]=7'h7F both, HEX[13:0] shows "42"; count 0 -> only digit 0 lit.
